// File: rtl/hps_param_loader_if.sv
// ---------------------------------------------------------------------------
// hps_param_loader_if
// Groups the three 32-bit HPS PIO words that carry the parameter-load
// handshake between the HPS (master) and hps_param_loader (slave).
//   pio_cmd    : HPS -> FPGA, [31] request toggle, [30] error-clear, [2:0] address
//   pio_data   : HPS -> FPGA, two's complement write data
//   pio_status : FPGA -> HPS, [31] ack toggle, [30] busy, [29] sticky error,
//                [28:16] zero, [15:0] commit count
// ---------------------------------------------------------------------------
interface hps_param_loader_if;
    logic [31:0] pio_cmd;
    logic [31:0] pio_data;
    logic [31:0] pio_status;

    modport master (
        output pio_cmd,
        output pio_data,
        input  pio_status
    );

    modport slave (
        input  pio_cmd,
        input  pio_data,
        output pio_status
    );
endinterface

// File: rtl/hps_param_loader.sv
// ---------------------------------------------------------------------------
// hps_param_loader
// Accepts Lorenz-integrator parameter / initial-condition writes from the HPS
// through a toggle request/acknowledge handshake. Writes land in shadow
// registers; a commit (address 7) copies all seven shadows into the active
// outputs on one edge and holds integ_restart high for HOLD_CYCLES cycles.
// Ports:
//   clk           : system clock (PIOs and integrator share it)
//   reset         : synchronous, active-low reset
//   bus           : PIO command/data/status words (slave side)
//   sigma..z0     : committed integrator values, signed 7.20 (DATA_W bits)
//   integ_restart : active-high restart pulse to the integrator
// ---------------------------------------------------------------------------
module hps_param_loader #(
    parameter int unsigned                DATA_W      = 27,
    parameter int unsigned                HOLD_CYCLES = 4,
    parameter logic signed [DATA_W-1:0]   SIGMA_RST   = 27'sd10485760,
    parameter logic signed [DATA_W-1:0]   RHO_RST     = 27'sd29360128,
    parameter logic signed [DATA_W-1:0]   BETA_RST    = 27'sd2796203,
    parameter logic signed [DATA_W-1:0]   DT_RST      = 27'sd4096,
    parameter logic signed [DATA_W-1:0]   X0_RST      = -27'sd1048576,
    parameter logic signed [DATA_W-1:0]   Y0_RST      = 27'sd104858,
    parameter logic signed [DATA_W-1:0]   Z0_RST      = 27'sd26214400
) (
    input  logic                      clk,
    input  logic                      reset,
    hps_param_loader_if.slave         bus,
    output logic signed [DATA_W-1:0]  sigma,
    output logic signed [DATA_W-1:0]  rho,
    output logic signed [DATA_W-1:0]  beta,
    output logic signed [DATA_W-1:0]  dt,
    output logic signed [DATA_W-1:0]  x0,
    output logic signed [DATA_W-1:0]  y0,
    output logic signed [DATA_W-1:0]  z0,
    output logic                      integ_restart
);

    localparam int unsigned NREG  = 7;
    // Bits [31:DATA_W-1] of the data word must all agree for a valid value.
    localparam int unsigned TOP_W = 33 - DATA_W;
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       ADDR_COMMIT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Reset value of register slot idx (address map order).
    function automatic logic [DATA_W-1:0] rst_val(input int idx);
        logic [DATA_W-1:0] v;
        case (idx)
            0:       v = SIGMA_RST;
            1:       v = RHO_RST;
            2:       v = BETA_RST;
            3:       v = DT_RST;
            4:       v = X0_RST;
            5:       v = Y0_RST;
            6:       v = Z0_RST;
            default: v = {DATA_W{1'b0}};
        endcase
        return v;
    endfunction

    // True when the 32-bit word does not fit in DATA_W signed bits.
    function automatic logic word_ovf(input logic [31:0] w);
        logic [TOP_W-1:0] top;
        top = w[31:DATA_W-1];
        return !((&top) || !(|top));
    endfunction

    // Narrow the 32-bit word to DATA_W bits, clamping out-of-range values.
    function automatic logic [DATA_W-1:0] word_sat(input logic [31:0] w);
        logic [DATA_W-1:0] v;
        if (word_ovf(w)) begin
            if (w[31]) begin
                v = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                v = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            v = w[DATA_W-1:0];
        end
        return v;
    endfunction

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               ack_q,      ack_d;
    logic               err_q,      err_d;
    logic [15:0]        count_q,    count_d;
    logic               restart_q,  restart_d;
    logic [DATA_W-1:0]  shadow_q [NREG];
    logic [DATA_W-1:0]  shadow_d [NREG];
    logic [DATA_W-1:0]  active_q [NREG];
    logic [DATA_W-1:0]  active_d [NREG];

    logic               pending_s;
    logic               clr_s;
    logic [2:0]         addr_s;
    logic               busy_s;
    logic               unused_s;

    assign pending_s = (bus.pio_cmd[31] != ack_q);
    assign clr_s     = bus.pio_cmd[30];
    assign addr_s    = bus.pio_cmd[2:0];
    assign busy_s    = (state_q != ST_IDLE);
    assign unused_s  = ^bus.pio_cmd[29:3];

    // Next-state, handshake, shadow and active register updates.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ack_d      = ack_q;
        err_d      = err_q;
        count_d    = count_q;
        restart_d  = restart_q;
        shadow_d   = shadow_q;
        active_d   = active_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    if (addr_s == ADDR_COMMIT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                for (int i = 0; i < NREG; i++) begin
                    if (addr_s == 3'(i)) begin
                        shadow_d[i] = word_sat(bus.pio_data);
                    end else begin
                        shadow_d[i] = shadow_q[i];
                    end
                end
                // Saturation sets the error even when the same request clears it.
                err_d   = word_ovf(bus.pio_data) | (err_q & ~clr_s);
                ack_d   = ~ack_q;
                state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                active_d   = shadow_q;
                restart_d  = 1'b1;
                count_d    = count_q + 16'd1;
                err_d      = err_q & ~clr_s;
                hold_cnt_d = {CNT_W{1'b0}};
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    restart_d  = 1'b0;
                    ack_d      = ~ack_q;
                    hold_cnt_d = {CNT_W{1'b0}};
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d    = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= {CNT_W{1'b0}};
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 16'd0;
            restart_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= rst_val(i);
                active_q[i] <= rst_val(i);
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            count_q    <= count_d;
            restart_q  <= restart_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    assign bus.pio_status = {ack_q, busy_s, err_q, 13'd0, count_q};
    assign sigma          = active_q[0];
    assign rho            = active_q[1];
    assign beta           = active_q[2];
    assign dt             = active_q[3];
    assign x0             = active_q[4];
    assign y0             = active_q[5];
    assign z0             = active_q[6];
    assign integ_restart  = restart_q;

endmodule
